alu_arbiter: RTL and testbench

ALU_ARBITER -- requirements
Module: alu_arbiter

---
 rtl/alu_arbiter.sv | 105 ++++++++++
 tb/tb_alu_arbiter.sv | 207 ++++++++++++++++++++
 2 files changed

// File: rtl/alu_arbiter.sv
// Round-robin arbiter that shares one external ALU between two requesters.
// Latency: an op accepted in cycle T has its response valid in cycle T+2; one op is in flight at a time.
// Backpressure: no new grant is issued until the owning requester consumes its response.
module alu_arbiter #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             req0_valid,
    output logic             req0_ready,
    input  logic [3:0]       req0_aluop,
    input  logic [5:0]       req0_func,
    input  logic [WIDTH-1:0] req0_a,
    input  logic [WIDTH-1:0] req0_b,
    input  logic             req1_valid,
    output logic             req1_ready,
    input  logic [3:0]       req1_aluop,
    input  logic [5:0]       req1_func,
    input  logic [WIDTH-1:0] req1_a,
    input  logic [WIDTH-1:0] req1_b,
    output logic             rsp0_valid,
    input  logic             rsp0_ready,
    output logic             rsp1_valid,
    input  logic             rsp1_ready,
    output logic [WIDTH-1:0] rsp_result,
    output logic             rsp_err,
    output logic [3:0]       alu_op,
    output logic [5:0]       alu_func,
    output logic [WIDTH-1:0] alu_a,
    output logic [WIDTH-1:0] alu_b,
    input  logic [3:0]       alu_ctl,
    input  logic [WIDTH-1:0] alu_result,
    output logic             busy
);
    typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;

    typedef struct packed {
        logic [3:0]       aluop;
        logic [5:0]       func;
        logic [WIDTH-1:0] a;
        logic [WIDTH-1:0] b;
        logic             id;
    } issue_t;

    state_t state;
    issue_t iss;
    logic   last_id;
    logic   grant0;
    logic   grant1;
    logic   owner_rdy;

    // On a tie the requester that was not served last wins.
    always_comb begin
        grant0 = req0_valid & (~req1_valid | last_id);
        grant1 = req1_valid & (~req0_valid | ~last_id);
    end

    assign req0_ready = (state == IDLE) & grant0;
    assign req1_ready = (state == IDLE) & grant1;

    assign owner_rdy  = iss.id ? rsp1_ready : rsp0_ready;
    assign rsp0_valid = (state == RESP) & ~iss.id;
    assign rsp1_valid = (state == RESP) &  iss.id;
    assign busy       = (state != IDLE);

    // ALU drive comes straight from the issue registers so it never glitches between ops.
    assign alu_op   = iss.aluop;
    assign alu_func = iss.func;
    assign alu_a    = iss.a;
    assign alu_b    = iss.b;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            iss        <= '0;
            last_id    <= 1'b1;
            rsp_result <= '0;
            rsp_err    <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (grant0) begin
                        iss   <= '{aluop: req0_aluop, func: req0_func, a: req0_a, b: req0_b, id: 1'b0};
                        state <= EXEC;
                    end else if (grant1) begin
                        iss   <= '{aluop: req1_aluop, func: req1_func, a: req1_a, b: req1_b, id: 1'b1};
                        state <= EXEC;
                    end
                end
                EXEC: begin
                    rsp_result <= alu_result;
                    rsp_err    <= (alu_ctl == 4'b1111);
                    state      <= RESP;
                end
                RESP: begin
                    if (owner_rdy) begin
                        last_id <= iss.id;
                        state   <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_alu_arbiter.sv
// Directed bench for alu_arbiter with a small behavioural ALU control decoder and ALU.
module tb_alu_arbiter;
    localparam int W = 32;

    logic          clk = 1'b0;
    logic          rst_n = 1'b1;
    logic          req0_valid = 1'b0, req1_valid = 1'b0;
    logic          req0_ready, req1_ready;
    logic [3:0]    req0_aluop = '0, req1_aluop = '0;
    logic [5:0]    req0_func = '0, req1_func = '0;
    logic [W-1:0]  req0_a = '0, req0_b = '0, req1_a = '0, req1_b = '0;
    logic          rsp0_valid, rsp1_valid;
    logic          rsp0_ready = 1'b0, rsp1_ready = 1'b0;
    logic [W-1:0]  rsp_result;
    logic          rsp_err;
    logic [3:0]    alu_op;
    logic [5:0]    alu_func;
    logic [W-1:0]  alu_a, alu_b;
    logic [3:0]    alu_ctl;
    logic [W-1:0]  alu_result;
    logic          busy;

    int checks = 0;
    int failures = 0;

    alu_arbiter #(.WIDTH(W)) dut (
        .clk(clk), .rst_n(rst_n),
        .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_aluop(req0_aluop),
        .req0_func(req0_func), .req0_a(req0_a), .req0_b(req0_b),
        .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_aluop(req1_aluop),
        .req1_func(req1_func), .req1_a(req1_a), .req1_b(req1_b),
        .rsp0_valid(rsp0_valid), .rsp0_ready(rsp0_ready),
        .rsp1_valid(rsp1_valid), .rsp1_ready(rsp1_ready),
        .rsp_result(rsp_result), .rsp_err(rsp_err),
        .alu_op(alu_op), .alu_func(alu_func), .alu_a(alu_a), .alu_b(alu_b),
        .alu_ctl(alu_ctl), .alu_result(alu_result), .busy(busy)
    );

    always #5 clk = ~clk;

    // Decoder: R-type add/sub/and/or by func, I-type 0000 add / 0001 sub, anything else invalid.
    always_comb begin
        alu_ctl = 4'b1111;
        if (alu_op[3]) begin
            case (alu_func)
                6'b100000: alu_ctl = 4'b0010;
                6'b100010: alu_ctl = 4'b0110;
                6'b100100: alu_ctl = 4'b0000;
                6'b100101: alu_ctl = 4'b0001;
                default:   alu_ctl = 4'b1111;
            endcase
        end else begin
            case (alu_op)
                4'b0000: alu_ctl = 4'b0010;
                4'b0001: alu_ctl = 4'b0110;
                default: alu_ctl = 4'b1111;
            endcase
        end
        case (alu_ctl)
            4'b0010: alu_result = alu_a + alu_b;
            4'b0110: alu_result = alu_a - alu_b;
            4'b0000: alu_result = alu_a & alu_b;
            4'b0001: alu_result = alu_a | alu_b;
            default: alu_result = 32'hBAD0_0BAD;
        endcase
    end

    task automatic test_reset;
        #2 rst_n = 1'b0;
        req0_valid = 1'b1;
        #1;
        checks++; if (busy !== 1'b0) begin failures++; $display("FAIL reset_busy got=%0b exp=0", busy); end
        checks++; if (rsp0_valid !== 1'b0 || rsp1_valid !== 1'b0) begin failures++; $display("FAIL reset_rsp_valid got=%0b%0b exp=00", rsp1_valid, rsp0_valid); end
        checks++; if (rsp_result !== 32'h0 || rsp_err !== 1'b0) begin failures++; $display("FAIL reset_rsp got=%0h/%0b exp=0/0", rsp_result, rsp_err); end
        checks++; if (alu_op !== 4'h0 || alu_func !== 6'h0 || alu_a !== 32'h0 || alu_b !== 32'h0) begin failures++; $display("FAIL reset_alu got=%0h %0h %0h %0h exp=0 0 0 0", alu_op, alu_func, alu_a, alu_b); end
        checks++; if (req0_ready !== 1'b1 || req1_ready !== 1'b0) begin failures++; $display("FAIL reset_ready got=%0b%0b exp=01", req1_ready, req0_ready); end
        @(negedge clk);
        checks++; if (busy !== 1'b0) begin failures++; $display("FAIL reset_hold_busy got=%0b exp=0", busy); end
        req0_valid = 1'b0;
        rst_n = 1'b1;
    endtask

    task automatic test_single;
        req0_valid = 1'b1; req0_aluop = 4'b1000; req0_func = 6'b100000; req0_a = 5; req0_b = 7;
        #1;
        checks++; if (req0_ready !== 1'b1 || req1_ready !== 1'b0) begin failures++; $display("FAIL single_ready got=%0b%0b exp=01", req1_ready, req0_ready); end
        @(negedge clk); req0_valid = 1'b0; #1;
        checks++; if (busy !== 1'b1 || rsp0_valid !== 1'b0 || req0_ready !== 1'b0) begin failures++; $display("FAIL single_exec got busy=%0b v=%0b r=%0b exp=1 0 0", busy, rsp0_valid, req0_ready); end
        checks++; if (alu_op !== 4'b1000 || alu_func !== 6'b100000 || alu_a !== 32'd5 || alu_b !== 32'd7) begin failures++; $display("FAIL single_alu got=%0h %0h %0d %0d exp=8 20 5 7", alu_op, alu_func, alu_a, alu_b); end
        @(negedge clk); #1;
        checks++; if (rsp0_valid !== 1'b1 || rsp1_valid !== 1'b0) begin failures++; $display("FAIL single_rsp_valid got=%0b%0b exp=01", rsp1_valid, rsp0_valid); end
        checks++; if (rsp_result !== 32'd12 || rsp_err !== 1'b0) begin failures++; $display("FAIL single_result got=%0d/%0b exp=12/0", rsp_result, rsp_err); end
        rsp0_ready = 1'b1;
        @(negedge clk); rsp0_ready = 1'b0; #1;
        checks++; if (busy !== 1'b0 || rsp0_valid !== 1'b0) begin failures++; $display("FAIL single_done got busy=%0b v=%0b exp=0 0", busy, rsp0_valid); end
        checks++; if (alu_a !== 32'd5 || alu_b !== 32'd7) begin failures++; $display("FAIL single_alu_hold got=%0d %0d exp=5 7", alu_a, alu_b); end
    endtask

    task automatic test_contention;
        logic e0;
        rst_n = 1'b0; #1 rst_n = 1'b1;
        req0_valid = 1'b1; req0_aluop = 4'b0000; req0_func = '0; req0_a = 10; req0_b = 3;
        req1_valid = 1'b1; req1_aluop = 4'b0001; req1_func = '0; req1_a = 10; req1_b = 3;
        rsp0_ready = 1'b1; rsp1_ready = 1'b1;
        for (int k = 0; k < 4; k++) begin
            e0 = (k % 2 == 0);
            #1;
            checks++; if (req0_ready !== e0 || req1_ready !== ~e0) begin failures++; $display("FAIL contend_grant%0d got=%0b%0b exp=%0b%0b", k, req1_ready, req0_ready, ~e0, e0); end
            @(negedge clk); @(negedge clk); #1;
            checks++; if (rsp0_valid !== e0 || rsp1_valid !== ~e0) begin failures++; $display("FAIL contend_route%0d got=%0b%0b exp=%0b%0b", k, rsp1_valid, rsp0_valid, ~e0, e0); end
            checks++; if (rsp_result !== (e0 ? 32'd13 : 32'd7)) begin failures++; $display("FAIL contend_result%0d got=%0d exp=%0d", k, rsp_result, e0 ? 13 : 7); end
            @(negedge clk);
        end
        req0_valid = 1'b0; req1_valid = 1'b0; rsp0_ready = 1'b0; rsp1_ready = 1'b0;
        #1;
    endtask

    task automatic test_backpressure;
        req1_valid = 1'b1; req1_aluop = 4'b1000; req1_func = 6'b100010; req1_a = 100; req1_b = 1;
        rsp0_ready = 1'b1; rsp1_ready = 1'b0;
        #1;
        checks++; if (req1_ready !== 1'b1) begin failures++; $display("FAIL bp_grant got=%0b exp=1", req1_ready); end
        @(negedge clk);
        req1_valid = 1'b0; req0_valid = 1'b1; req0_aluop = 4'b0000; req0_a = 1; req0_b = 2;
        #1;
        checks++; if (req0_ready !== 1'b0) begin failures++; $display("FAIL bp_exec_ready got=%0b exp=0", req0_ready); end
        @(negedge clk);
        for (int i = 0; i < 5; i++) begin
            #1;
            checks++; if (rsp1_valid !== 1'b1 || rsp0_valid !== 1'b0 || rsp_result !== 32'd99 || req0_ready !== 1'b0) begin failures++; $display("FAIL bp_hold%0d got v1=%0b v0=%0b res=%0d r0=%0b exp=1 0 99 0", i, rsp1_valid, rsp0_valid, rsp_result, req0_ready); end
            @(negedge clk);
        end
        #1;
        checks++; if (rsp1_valid !== 1'b1) begin failures++; $display("FAIL bp_still_valid got=%0b exp=1", rsp1_valid); end
        rsp1_ready = 1'b1;
        @(negedge clk); rsp1_ready = 1'b0; rsp0_ready = 1'b0; #1;
        checks++; if (rsp1_valid !== 1'b0 || req0_ready !== 1'b1) begin failures++; $display("FAIL bp_release got v1=%0b r0=%0b exp=0 1", rsp1_valid, req0_ready); end
        req0_valid = 1'b0;
        @(negedge clk); #1;
        checks++; if (busy !== 1'b0) begin failures++; $display("FAIL bp_withdraw got=%0b exp=0", busy); end
    endtask

    task automatic test_invalid;
        req1_valid = 1'b1; req1_aluop = 4'b0100; req1_func = '0; req1_a = 3; req1_b = 4;
        #1;
        checks++; if (req1_ready !== 1'b1) begin failures++; $display("FAIL inv_grant got=%0b exp=1", req1_ready); end
        @(negedge clk); req1_valid = 1'b0;
        @(negedge clk); #1;
        checks++; if (rsp1_valid !== 1'b1 || rsp0_valid !== 1'b0 || rsp_err !== 1'b1) begin failures++; $display("FAIL inv_err got v1=%0b v0=%0b err=%0b exp=1 0 1", rsp1_valid, rsp0_valid, rsp_err); end
        checks++; if (rsp_result !== 32'hBAD0_0BAD) begin failures++; $display("FAIL inv_result got=%0h exp=bad00bad", rsp_result); end
        rsp1_ready = 1'b1;
        @(negedge clk); rsp1_ready = 1'b0; #1;
        checks++; if (busy !== 1'b0) begin failures++; $display("FAIL inv_done got=%0b exp=0", busy); end
    endtask

    task automatic test_reset_in_resp;
        req0_valid = 1'b1; req0_aluop = 4'b1000; req0_func = 6'b100100; req0_a = 32'hF0; req0_b = 32'h3C;
        @(negedge clk); req0_valid = 1'b0;
        @(negedge clk); #1;
        checks++; if (rsp0_valid !== 1'b1 || rsp_result !== 32'h30) begin failures++; $display("FAIL rr_pre got v=%0b res=%0h exp=1 30", rsp0_valid, rsp_result); end
        rst_n = 1'b0; #1;
        checks++; if (rsp0_valid !== 1'b0 || busy !== 1'b0 || rsp_result !== 32'h0 || rsp_err !== 1'b0) begin failures++; $display("FAIL rr_async got v=%0b busy=%0b res=%0h err=%0b exp=0 0 0 0", rsp0_valid, busy, rsp_result, rsp_err); end
        checks++; if (alu_a !== 32'h0 || alu_op !== 4'h0 || alu_func !== 6'h0) begin failures++; $display("FAIL rr_alu got=%0h %0h %0h exp=0 0 0", alu_a, alu_op, alu_func); end
        @(negedge clk); rst_n = 1'b1; rsp0_ready = 1'b1;
        @(negedge clk); #1;
        checks++; if (rsp0_valid !== 1'b0 || busy !== 1'b0) begin failures++; $display("FAIL rr_discard got v=%0b busy=%0b exp=0 0", rsp0_valid, busy); end
        rsp0_ready = 1'b0;
        req0_valid = 1'b1; req0_func = 6'b100101; req0_a = 32'hF0; req0_b = 32'h0F;
        req1_valid = 1'b1; req1_aluop = 4'b0000; req1_a = 1; req1_b = 1;
        #1;
        checks++; if (req0_ready !== 1'b1 || req1_ready !== 1'b0) begin failures++; $display("FAIL rr_regrant got=%0b%0b exp=01", req1_ready, req0_ready); end
        @(negedge clk); req0_valid = 1'b0; req1_valid = 1'b0;
        @(negedge clk); #1;
        checks++; if (rsp0_valid !== 1'b1 || rsp_result !== 32'hFF) begin failures++; $display("FAIL rr_after got v=%0b res=%0h exp=1 ff", rsp0_valid, rsp_result); end
        rsp0_ready = 1'b1;
        @(negedge clk); rsp0_ready = 1'b0; #1;
    endtask

    task automatic test_isolation;
        req1_valid = 1'b1; req1_aluop = 4'b0000; req1_a = 1; req1_b = 1;
        @(negedge clk);
        req1_valid = 1'b0; req0_valid = 1'b1; req0_aluop = 4'b0000; req0_a = 1; req0_b = 1;
        #1;
        checks++; if (req0_ready !== 1'b0) begin failures++; $display("FAIL iso_busy_ready got=%0b exp=0", req0_ready); end
        @(negedge clk); req0_a = 2; req0_b = 2; rsp1_ready = 1'b1;
        @(negedge clk); rsp1_ready = 1'b0; req0_a = 20; req0_b = 22; #1;
        checks++; if (req0_ready !== 1'b1) begin failures++; $display("FAIL iso_grant got=%0b exp=1", req0_ready); end
        @(negedge clk); req0_a = 99; req0_b = 99; req0_valid = 1'b0; #1;
        checks++; if (alu_a !== 32'd20 || alu_b !== 32'd22) begin failures++; $display("FAIL iso_operands got=%0d %0d exp=20 22", alu_a, alu_b); end
        @(negedge clk); #1;
        checks++; if (rsp0_valid !== 1'b1 || rsp_result !== 32'd42) begin failures++; $display("FAIL iso_result got v=%0b res=%0d exp=1 42", rsp0_valid, rsp_result); end
        rsp0_ready = 1'b1;
        @(negedge clk); rsp0_ready = 1'b0; #1;
    endtask

    initial begin
        test_reset();
        test_single();
        test_contention();
        test_backpressure();
        test_invalid();
        test_reset_in_resp();
        test_isolation();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
